// File: rtl/tag_control_pkg.sv
// tag_control_pkg
//   Shared types and defaults for the tag allocator.
//   - TAG_COUNT         : default number of tags in circulation
//   - tag_buffer_state  : allocator sequencing states
//   - CommandTagLine    : per-command metadata stored with each tag
//   - BufferStatus      : FIFO status bundle
package tag_control_pkg;

  localparam int TAG_COUNT = 32;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    INIT  = 2'd1,
    POP   = 2'd2,
    READY = 2'd3
  } tag_buffer_state;

  typedef struct packed {
    logic [7:0]  tag;
    logic [3:0]  cu_id;
    logic [31:0] address_offest;
  } CommandTagLine;

  typedef struct packed {
    logic full;
    logic alfull;
    logic valid;
    logic empty;
  } BufferStatus;

endpackage

// File: rtl/tag_control_if.sv
// tag_control_if
//   Bundles the command-stage and PSL response signals of the tag allocator.
//   slave  : tag_control side (grants tags, returns stored metadata)
//   master : arbiter / PSL side
interface tag_control_if;
  import tag_control_pkg::*;

  logic          enabled_in;
  logic          tag_request_in;
  CommandTagLine cmd_tag_line_in;
  logic          tag_ready_out;
  logic          tag_valid_out;
  logic [7:0]    tag_out;
  logic          response_valid_in;
  logic [7:0]    response_tag_in;
  CommandTagLine cmd_tag_line_out;
  logic          cmd_tag_valid_out;
  logic [8:0]    free_count_out;

  modport slave (
    input  enabled_in, tag_request_in, cmd_tag_line_in,
           response_valid_in, response_tag_in,
    output tag_ready_out, tag_valid_out, tag_out,
           cmd_tag_line_out, cmd_tag_valid_out, free_count_out
  );

  modport master (
    output enabled_in, tag_request_in, cmd_tag_line_in,
           response_valid_in, response_tag_in,
    input  tag_ready_out, tag_valid_out, tag_out,
           cmd_tag_line_out, cmd_tag_valid_out, free_count_out
  );
endinterface

// File: rtl/tag_control_fifo.sv
// tag_fifo
//   Synchronous show-ahead FIFO holding free tags.
//   clock, rstn : clock / async active-low reset
//   push, data_in : write request and data (ignored when full)
//   pop           : consume head (ignored when empty)
//   data_out      : current head entry
//   status        : full / alfull / valid / empty
module tag_fifo
  import tag_control_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output BufferStatus      status
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage is not reset; pointers define what is live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  assign data_out      = mem[rd_ptr];
  assign status.full   = (count == CNT_W'(DEPTH));
  assign status.alfull = (count >= CNT_W'(DEPTH - 1));
  assign status.empty  = (count == '0);
  assign status.valid  = (count != '0);
endmodule

// File: rtl/tag_control.sv
// tag_control
//   Hands out free command tags, remembers each command's CommandTagLine,
//   restores it when the PSL response arrives and recycles the tag.
//   clock, rstn : clock / async active-low reset
//   bus         : tag_control_if.slave (request/grant, response/lookup, status)
module tag_control
  import tag_control_pkg::*;
#(
  parameter int TAG_COUNT = tag_control_pkg::TAG_COUNT
) (
  input  logic         clock,
  input  logic         rstn,
  tag_control_if.slave bus
);
  localparam int         IDX_W     = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;
  localparam logic [8:0] TAG_LIMIT = 9'(TAG_COUNT);
  localparam logic [7:0] LAST_TAG  = 8'(TAG_COUNT - 1);

  tag_buffer_state state;
  logic [7:0]      init_cnt;
  logic [8:0]      free_count;
  logic            tag_valid;
  logic [7:0]      tag_q;
  logic            cmd_valid;
  CommandTagLine   cmd_line;

  CommandTagLine   tag_table [TAG_COUNT];
  CommandTagLine   resp_line;

  BufferStatus     fifo_status;
  logic [7:0]      fifo_head;
  logic [7:0]      fifo_din;
  logic            fifo_push;
  logic            fifo_pop;
  logic            tag_ready;
  logic            grant;
  logic            resp_ok;
  logic            status_unused;

  assign tag_ready = (state == READY) && !fifo_status.empty;
  assign grant     = bus.tag_request_in && tag_ready;
  assign resp_ok   = bus.response_valid_in && (state == READY) &&
                     ({1'b0, bus.response_tag_in} < TAG_LIMIT);

  assign fifo_push = (state == INIT) || resp_ok;
  assign fifo_din  = (state == INIT) ? init_cnt : bus.response_tag_in;
  assign fifo_pop  = grant;

  assign status_unused = fifo_status.alfull;

  tag_fifo #(
    .DEPTH (TAG_COUNT),
    .WIDTH (8)
  ) u_fifo (
    .clock    (clock),
    .rstn     (rstn),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (fifo_din),
    .data_out (fifo_head),
    .status   (fifo_status)
  );

  always_ff @(posedge clock) begin
    if (grant) tag_table[fifo_head[IDX_W-1:0]] <= bus.cmd_tag_line_in;
  end

  // Lookup carries the responding tag rather than whatever was stored.
  always_comb begin
    resp_line     = tag_table[bus.response_tag_in[IDX_W-1:0]];
    resp_line.tag = bus.response_tag_in;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= RESET;
      init_cnt   <= '0;
      free_count <= '0;
      tag_valid  <= 1'b0;
      tag_q      <= '0;
      cmd_valid  <= 1'b0;
      cmd_line   <= '0;
    end else begin
      tag_valid <= 1'b0;
      cmd_valid <= 1'b0;

      case (state)
        RESET: begin
          init_cnt <= '0;
          if (bus.enabled_in) state <= INIT;
        end
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_TAG) state <= POP;
        end
        POP:   state <= READY;
        READY: begin
          if (grant) begin
            tag_valid <= 1'b1;
            tag_q     <= fifo_head;
          end
          if (resp_ok) begin
            cmd_valid <= 1'b1;
            cmd_line  <= resp_line;
          end
        end
        default: state <= RESET;
      endcase

      // Push is never refused in practice: at most TAG_COUNT tags exist.
      if (fifo_push && !fifo_pop && !fifo_status.full)
        free_count <= free_count + 1'b1;
      else if (fifo_pop && !fifo_push && fifo_status.valid)
        free_count <= free_count - 1'b1;
    end
  end

  assign bus.tag_ready_out     = tag_ready;
  assign bus.tag_valid_out     = tag_valid;
  assign bus.tag_out           = tag_q;
  assign bus.cmd_tag_valid_out = cmd_valid;
  assign bus.cmd_tag_line_out  = cmd_line;
  assign bus.free_count_out    = free_count;
endmodule

// File: tb/tb_tag_control.sv
module tb_tag_control;
  import tag_control_pkg::*;

  localparam int NTAG = 32;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  always #5 clock = ~clock;

  tag_control_if bus();

  tag_control #(.TAG_COUNT(NTAG)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: free pool, table contents, outstanding tags, and
  // scoreboard queues of expected grant / lookup results.
  logic          model_ready = 1'b0;
  logic [7:0]    pool[$];
  logic [7:0]    outst[$];
  CommandTagLine mtab [256];
  logic [7:0]    exp_grant_q[$];
  CommandTagLine exp_resp_q[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    pool.delete();
    outst.delete();
    exp_grant_q.delete();
    exp_resp_q.delete();
    model_ready = 1'b0;
  endtask

  task automatic model_fill();
    for (int i = 0; i < NTAG; i++) pool.push_back(8'(i));
    model_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},     64'(bus.tag_ready_out), 64'd0);
    chk({tag, "_tvalid"},    64'(bus.tag_valid_out), 64'd0);
    chk({tag, "_tag"},       64'(bus.tag_out), 64'd0);
    chk({tag, "_cvalid"},    64'(bus.cmd_tag_valid_out), 64'd0);
    chk({tag, "_cline"},     64'(bus.cmd_tag_line_out), 64'd0);
    chk({tag, "_freecount"}, 64'(bus.free_count_out), 64'd0);
  endtask

  // Runs from reset-released RESET state with enabled_in high.
  task automatic run_init(input string tag);
    bus.enabled_in = 1'b1;
    for (int i = 1; i <= NTAG + 2; i++) begin
      tick();
      if (i == NTAG + 1) begin
        chk({tag, "_ready_early"}, 64'(bus.tag_ready_out), 64'd0);
        chk({tag, "_count_filled"}, 64'(bus.free_count_out), 64'(NTAG));
      end
    end
    chk({tag, "_ready_rise"}, 64'(bus.tag_ready_out), 64'd1);
    chk({tag, "_count_ready"}, 64'(bus.free_count_out), 64'(NTAG));
    model_fill();
  endtask

  // One clock of traffic: drive, update the model, clock, compare.
  task automatic cycle(input logic req, input CommandTagLine line,
                       input logic rv, input logic [7:0] rt);
    logic          exp_ready;
    logic [7:0]    t;
    CommandTagLine e;
    exp_ready = model_ready && (pool.size() > 0);
    chk("ready_pre", 64'(bus.tag_ready_out), 64'(exp_ready));

    bus.tag_request_in    = req;
    bus.cmd_tag_line_in   = line;
    bus.response_valid_in = rv;
    bus.response_tag_in   = rt;

    if (req && exp_ready) begin
      t = pool.pop_front();
      mtab[t] = line;
      outst.push_back(t);
      exp_grant_q.push_back(t);
    end
    if (rv && model_ready && (int'(rt) < NTAG)) begin
      e = mtab[rt];
      e.tag = rt;
      exp_resp_q.push_back(e);
      pool.push_back(rt);
      for (int i = 0; i < outst.size(); i++)
        if (outst[i] == rt) begin
          outst.delete(i);
          break;
        end
    end

    tick();
    bus.tag_request_in    = 1'b0;
    bus.response_valid_in = 1'b0;

    if (exp_grant_q.size() > 0) begin
      t = exp_grant_q.pop_front();
      chk("grant_valid", 64'(bus.tag_valid_out), 64'd1);
      chk("grant_tag",   64'(bus.tag_out), 64'(t));
    end else begin
      chk("no_grant", 64'(bus.tag_valid_out), 64'd0);
    end
    if (exp_resp_q.size() > 0) begin
      e = exp_resp_q.pop_front();
      chk("resp_valid", 64'(bus.cmd_tag_valid_out), 64'd1);
      chk("resp_line",  64'(bus.cmd_tag_line_out), 64'(e));
    end else begin
      chk("no_resp", 64'(bus.cmd_tag_valid_out), 64'd0);
    end
    chk("free_count", 64'(bus.free_count_out), 64'(pool.size()));
  endtask

  CommandTagLine ln;
  CommandTagLine zero_line;
  logic [7:0]    rtag;

  initial begin
    zero_line             = '0;
    bus.enabled_in        = 1'b0;
    bus.tag_request_in    = 1'b0;
    bus.cmd_tag_line_in   = '0;
    bus.response_valid_in = 1'b0;
    bus.response_tag_in   = '0;
    model_reset();

    // Reset values
    rstn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // Held in RESET while enabled_in is low
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_ready", 64'(bus.tag_ready_out), 64'd0);
    chk("idle_count", 64'(bus.free_count_out), 64'd0);

    // Init latency TAG_COUNT+2
    run_init("init");

    // Drain the pool back-to-back; tag 5 carries known metadata
    for (int i = 0; i < NTAG; i++) begin
      ln.tag            = 8'hEE;
      ln.cu_id          = 4'(i);
      ln.address_offest = $urandom;
      if (i == 5) begin
        ln.cu_id          = 4'd3;
        ln.address_offest = 32'h0000_1000;
      end
      cycle(1'b1, ln, 1'b0, 8'd0);
      chk("inorder_tag", 64'(bus.tag_out), 64'(i));
    end
    chk("empty_ready", 64'(bus.tag_ready_out), 64'd0);
    cycle(1'b1, zero_line, 1'b0, 8'd0);
    chk("empty_no_grant", 64'(bus.tag_valid_out), 64'd0);

    // Lookup of tag 5
    cycle(1'b0, zero_line, 1'b1, 8'd5);
    chk("lookup_valid", 64'(bus.cmd_tag_valid_out), 64'd1);
    chk("lookup_cu_id", 64'(bus.cmd_tag_line_out.cu_id), 64'd3);
    chk("lookup_addr",  64'(bus.cmd_tag_line_out.address_offest), 64'h1000);
    chk("lookup_tag",   64'(bus.cmd_tag_line_out.tag), 64'd5);

    // Freed tag 5 reissued next cycle
    ln = '{tag: 8'h00, cu_id: 4'd9, address_offest: 32'h2222_0000};
    cycle(1'b1, ln, 1'b0, 8'd0);
    chk("reuse_tag5", 64'(bus.tag_out), 64'd5);

    // Empty pool: release and request in same cycle -> no grant, retry wins
    cycle(1'b1, ln, 1'b1, 8'd7);
    chk("same_cycle_no_grant", 64'(bus.tag_valid_out), 64'd0);
    cycle(1'b1, ln, 1'b0, 8'd0);
    chk("retry_valid", 64'(bus.tag_valid_out), 64'd1);
    chk("retry_tag7",  64'(bus.tag_out), 64'd7);

    // Seed four free tags, then 100 cycles of grant + release together
    for (int i = 10; i < 14; i++) cycle(1'b0, zero_line, 1'b1, 8'(i));
    for (int i = 0; i < 100; i++) begin
      ln.tag            = 8'(i);
      ln.cu_id          = 4'($urandom_range(15));
      ln.address_offest = $urandom;
      rtag = outst[0];
      cycle(1'b1, ln, 1'b1, rtag);
      chk("steady_count", 64'(bus.free_count_out), 64'd4);
    end

    // Out-of-range response is ignored
    cycle(1'b0, zero_line, 1'b1, 8'd200);
    chk("oor_no_lookup", 64'(bus.cmd_tag_valid_out), 64'd0);
    chk("oor_count", 64'(bus.free_count_out), 64'd4);

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      rtag = outst[0];
      cycle(1'b1, zero_line, 1'b1, rtag);
    end
    bus.tag_request_in    = 1'b1;
    bus.response_valid_in = 1'b1;
    rstn = 1'b0;
    #2;
    check_reset_outputs("midreset");
    bus.tag_request_in    = 1'b0;
    bus.response_valid_in = 1'b0;
    model_reset();
    tick();
    rstn = 1'b1;
    run_init("reinit");
    cycle(1'b1, zero_line, 1'b0, 8'd0);
    chk("reinit_first_tag", 64'(bus.tag_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
